dm_copy_engine: RTL and testbench

DM_COPY_ENGINE -- requirements
Module: dm_copy_engine

---
 rtl/dm_copy_engine.sv | 126 ++++++++++++
 tb/tb_dm_copy_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_copy_engine.sv
// dm_copy_engine: byte-sequential memory-to-memory copy engine.
// Each byte takes one READ cycle and one WRITE cycle against a single-port
// data memory with combinational read data. Optional feature macro:
// DM_COPY_CHECKSUM_EN enables a running modulo-2^DATA_W sum of copied bytes;
// without it the checksum port is tied to zero.
module dm_copy_engine #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] writeData,
   output logic              readMem,
   output logic              writeMem,
   input  logic [DATA_W-1:0] readData,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   state_t            state, state_nx;
   mem_req_t          req;
   logic [ADDR_W-1:0] src_ptr, dst_ptr, remaining;
   logic [DATA_W-1:0] byte_q;
   logic              accept;

   // a start only counts while idle; busy-time pulses are dropped
   assign accept = (state == IDLE) && start;

   // state register, reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state: two cycles per byte, a zero-length start goes straight to DONE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (len != '0) ? READ : DONE;
         READ:    state_nx = WRITE;
         WRITE:   state_nx = (remaining == ADDR_W'(1)) ? DONE : READ;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // memory request: strobes only in READ/WRITE, bus parked at zero otherwise
   always_comb begin
      req = '0;
      case (state)
         READ: begin
            req.rd   = 1'b1;
            req.addr = src_ptr;
         end
         WRITE: begin
            req.wr    = 1'b1;
            req.addr  = dst_ptr;
            req.wdata = byte_q;
         end
         default: req = '0;
      endcase
   end

   assign readMem   = req.rd;
   assign writeMem  = req.wr;
   assign Address   = req.addr;
   assign writeData = req.wdata;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // operand latch, byte capture and pointer advance (pointers wrap naturally)
   always_ff @(posedge clk) begin
      if (rst) begin
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         byte_q    <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               src_ptr   <= src;
               dst_ptr   <= dst;
               remaining <= len;
            end
            READ: byte_q <= readData;
            WRITE: begin
               src_ptr   <= src_ptr + 1'b1;
               dst_ptr   <= dst_ptr + 1'b1;
               remaining <= remaining - 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef DM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] csum;

   // running sum of written bytes, cleared by an accepted start, held after done
   always_ff @(posedge clk) begin
      if (rst)                  csum <= '0;
      else if (accept)          csum <= '0;
      else if (state == WRITE)  csum <= csum + byte_q;
   end

   assign checksum = csum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_dm_copy_engine.sv
// tb_dm_copy_engine: randomized bench with a transfer-level reference model.
// On every accepted start the model expands the copy into its expected
// per-cycle bus activity (READ/WRITE pairs then DONE) using a copy of the
// reference memory; a negedge process compares the DUT against that schedule.
// Honours DM_COPY_CHECKSUM_EN for the expected checksum.
module tb_dm_copy_engine;

`ifdef DM_COPY_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] src = '0, dst = '0, len = '0;
   logic       busy, done, readMem, writeMem;
   logic [7:0] Address, writeData, readData, checksum;

   dm_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .Address(Address), .writeData(writeData),
      .readMem(readMem), .writeMem(writeMem), .readData(readData),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   // data memory: combinational read; write port held off while rst is high
   logic [7:0] mem [256];
   assign readData = mem[Address];
   always @(posedge clk) if (writeMem && !rst) mem[Address] <= writeData;

   typedef struct {
      bit       busy, done, rd, wr;
      bit [7:0] addr, wdata, csum;
   } exp_t;

   logic [7:0] ref_mem [256];
   exp_t       q[$];
   exp_t       cur;
   bit         cur_busy = 1'b0;
   bit [7:0]   held = '0;
   int         cyc = 0, acc_cyc = 0, done_cyc = 0;
   int         done_cnt = 0, busy_cnt = 0, rd_cnt = 0, wr_cnt = 0;
   int         checks = 0, errors = 0;

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, got, exp);
      end
   endtask

   // expand one accepted transfer into its expected cycle schedule
   task automatic build(input bit [7:0] s, input bit [7:0] d, input int l);
      logic [7:0] tmp [256];
      bit [7:0]   sum = '0, a, b, v;
      exp_t       e;
      tmp = ref_mem;
      for (int i = 0; i < l; i++) begin
         a = s + 8'(i);
         b = d + 8'(i);
         v = tmp[a];
         e = '{busy:1, done:0, rd:1, wr:0, addr:a, wdata:0, csum:(CS_EN ? sum : 8'd0)};
         q.push_back(e);
         e = '{busy:1, done:0, rd:0, wr:1, addr:b, wdata:v, csum:(CS_EN ? sum : 8'd0)};
         q.push_back(e);
         tmp[b] = v;
         sum += v;
      end
      e = '{busy:1, done:1, rd:0, wr:0, addr:0, wdata:0, csum:(CS_EN ? sum : 8'd0)};
      q.push_back(e);
   endtask

   // model advance: reset flush, write commit, start acceptance
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         held = '0;
      end else begin
         if (cur_busy && cur.wr) ref_mem[cur.addr] = cur.wdata;
         if (start && !cur_busy) begin
            acc_cyc = cyc;
            build(src, dst, int'(len));
         end
      end
   end

   // per-cycle compare of all outputs against the schedule
   always @(negedge clk) begin
      if (cyc > 0) begin
         if (q.size() > 0) begin
            cur = q.pop_front();
            cur_busy = 1'b1;
         end else begin
            cur = '{busy:0, done:0, rd:0, wr:0, addr:0, wdata:0, csum:held};
            cur_busy = 1'b0;
         end
         checks++;
         if (busy !== cur.busy || done !== cur.done || readMem !== cur.rd ||
             writeMem !== cur.wr || Address !== cur.addr ||
             writeData !== cur.wdata || checksum !== cur.csum) begin
            errors++;
            $display("FAIL cycle %0d outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wd=%h cs=%h expected busy=%b done=%b rd=%b wr=%b addr=%h wd=%h cs=%h",
                     cyc, busy, done, readMem, writeMem, Address, writeData, checksum,
                     cur.busy, cur.done, cur.rd, cur.wr, cur.addr, cur.wdata, cur.csum);
         end
         if (cur_busy) held = cur.csum;
         if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         if (busy === 1'b1) busy_cnt++;
         if (readMem === 1'b1) rd_cnt++;
         if (writeMem === 1'b1) wr_cnt++;
      end
   end

   task automatic poke(input bit [7:0] a, input bit [7:0] v);
      mem[a] = v;
      ref_mem[a] = v;
   endtask

   // issue one transfer; noise: 0 none, 1 random, 2 every cycle of busy-time starts
   task automatic run(input bit [7:0] s, input bit [7:0] d, input bit [7:0] l,
                      input int noise, input int rst_at);
      @(posedge clk); #1;
      start = 1'b1; src = s; dst = d; len = l;
      @(posedge clk); #1;
      start = 1'b0; src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) break;
         if (k == rst_at) begin
            start = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            break;
         end
         if (noise == 2 || (noise == 1 && $urandom_range(0, 2) == 0)) begin
            start = 1'b1;
            src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom_range(1, 5));
         end else start = 1'b0;
         if (k == 39) chk("done_timeout", 0, 1);
      end
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   int d_done, d_busy, d_rd, d_wr;

   task automatic snap;
      d_done = done_cnt; d_busy = busy_cnt; d_rd = rd_cnt; d_wr = wr_cnt;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) poke(8'(i), 8'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_checksum", int'(checksum), 0);

      // single byte
      poke(8'd1, 8'd6);
      snap();
      run(8'd1, 8'd5, 8'd1, 0, -1);
      chk("b1_done_lat", done_cyc - acc_cyc, 2);
      chk("b1_mem5", int'(mem[5]), 6);
      chk("b1_rd", rd_cnt - d_rd, 1);
      chk("b1_wr", wr_cnt - d_wr, 1);
      chk("b1_csum", int'(checksum), CS_EN ? 6 : 0);

      // four bytes
      for (int i = 0; i < 4; i++) poke(8'(i), 8'(i + 1));
      snap();
      run(8'd0, 8'd4, 8'd4, 0, -1);
      for (int i = 0; i < 4; i++) chk($sformatf("b4_mem%0d", i + 4), int'(mem[i + 4]), i + 1);
      chk("b4_busy_cycles", busy_cnt - d_busy, 9);
      chk("b4_csum", int'(checksum), CS_EN ? 10 : 0);

      // zero length
      snap();
      run(8'd0, 8'd4, 8'd0, 0, -1);
      chk("z_rd", rd_cnt - d_rd, 0);
      chk("z_wr", wr_cnt - d_wr, 0);
      chk("z_done_cnt", done_cnt - d_done, 1);
      chk("z_done_lat", done_cyc - acc_cyc, 0);
      chk("z_mem4", int'(mem[4]), 1);
      chk("z_csum", int'(checksum), 0);

      // address wrap
      poke(8'd255, 8'd9);
      poke(8'd0, 8'd7);
      run(8'd255, 8'd16, 8'd2, 0, -1);
      chk("w_mem16", int'(mem[16]), 9);
      chk("w_mem17", int'(mem[17]), 7);

      // reset during the second write
      for (int i = 0; i < 4; i++) poke(8'(8'h20 + i), 8'(8'hA1 + i));
      run(8'h20, 8'h40, 8'd4, 0, 3);
      chk("r_mem40", int'(mem[8'h40]), 8'hA1);
      chk("r_mem41", int'(mem[8'h41]), 0);
      chk("r_busy", int'(busy), 0);
      chk("r_csum", int'(checksum), 0);
      run(8'h20, 8'h50, 8'd4, 0, -1);
      chk("r_mem53", int'(mem[8'h53]), 8'hA4);

      // starts while busy are ignored
      snap();
      run(8'h20, 8'h60, 8'd3, 2, -1);
      chk("n_done_cnt", done_cnt - d_done, 1);
      chk("n_mem60", int'(mem[8'h60]), 8'hA1);
      chk("n_mem62", int'(mem[8'h62]), 8'hA3);

      // randomized traffic, including overlapping ranges and the odd reset
      for (int t = 0; t < 40; t++) begin
         for (int j = 0; j < 3; j++) poke(8'($urandom), 8'($urandom));
         run(8'($urandom), 8'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 4)),
             8'($urandom_range(0, 6)), $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1);
      end
      repeat (2) @(posedge clk);
      for (int i = 0; i < 256; i++) chk($sformatf("mem%0d", i), int'(mem[i]), int'(ref_mem[i]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
